// File: rtl/muldiv_if.sv
// Muldiv unit bundle between the EX stage (master) and the multiply/divide sequencer (slave).
// Handshake: Start is the EX-side valid and ~Stall is the ready; a Start is consumed on an
// edge where the unit is idle and Cancel is low, otherwise EX holds Start/Op/A/B unchanged.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ReadHiLo;
  logic             Cancel;
  logic             Stall;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output Start, Op, A, B, ReadHiLo, Cancel,
    input  Stall, Busy, Done, Hi, Lo
  );

  modport slave (
    input  Start, Op, A, B, ReadHiLo, Cancel,
    output Stall, Busy, Done, Hi, Lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit with HI/LO registers: WIDTH shift-add or restoring steps
// followed by a sign-fix cycle, so every MUL/DIV takes exactly WIDTH+1 cycles.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic       Clk,
  input  logic       Rst,
  muldiv_if.slave    bus,
  output logic [1:0] o_state
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_busy;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_is_div;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic               r_bzero;

  logic               w_accept;
  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_trial;
  logic               w_div_ge;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  assign w_accept = (r_state == S_IDLE) & bus.Start & ~bus.Cancel;
  assign w_signed = (bus.Op == OP_MULT) | (bus.Op == OP_DIV);
  assign w_a_neg  = w_signed & bus.A[WIDTH-1];
  assign w_b_neg  = w_signed & bus.B[WIDTH-1];
  assign w_abs_a  = w_a_neg ? -bus.A : bus.A;
  assign w_abs_b  = w_b_neg ? -bus.B : bus.B;

  // Multiply: add multiplicand into the upper half, then shift the whole accumulator right.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_opb[0] ? {1'b0, r_opa} : '0);

  // Divide: upper half is the partial remainder, lower half shifts the dividend out / quotient in.
  // The remainder stays below the divisor, so the trial MSB is a clean borrow flag.
  assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_trial = w_div_shift - {1'b0, r_opb};
  assign w_div_ge    = ~w_div_trial[WIDTH];

  // Divide by zero keeps the all-ones quotient unnegated; the remainder is then |A| re-signed, i.e. A.
  assign w_prod   = r_neg_res ? -r_acc : r_acc;
  assign w_quo    = (r_neg_res & ~r_bzero) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem    = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  assign w_fix_hi = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
  assign w_fix_lo = r_is_div ? w_quo : w_prod[WIDTH-1:0];

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (bus.Op)
            OP_MULT, OP_MULTU: w_next = S_MUL;
            OP_DIV, OP_DIVU:   w_next = S_DIV;
            default:           w_next = S_IDLE;
          endcase
        end
      end
      S_MUL, S_DIV: begin
        w_busy = 1'b1;
        if (bus.Cancel)          w_next = S_IDLE;
        else if (r_cnt == LAST)  w_next = S_FIX;
      end
      S_FIX: begin
        w_busy = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_bzero   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (bus.Op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                r_is_div  <= (bus.Op == OP_DIV) | (bus.Op == OP_DIVU);
                r_opa     <= w_abs_a;
                r_opb     <= w_abs_b;
                r_cnt     <= '0;
                r_acc     <= ((bus.Op == OP_DIV) | (bus.Op == OP_DIVU)) ?
                             {{WIDTH{1'b0}}, w_abs_a} : '0;
                r_neg_res <= w_a_neg ^ w_b_neg;
                r_neg_rem <= w_a_neg;
                r_bzero   <= (bus.B == '0);
              end
              OP_MTHI: r_hi <= bus.A;
              OP_MTLO: r_lo <= bus.A;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (!bus.Cancel) begin
            r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
            r_opb <= r_opb >> 1;
            r_cnt <= r_cnt + ONE;
          end
        end
        S_DIV: begin
          if (!bus.Cancel) begin
            r_acc <= w_div_ge ? {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                              : {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            r_cnt <= r_cnt + ONE;
          end
        end
        S_FIX: begin
          if (!bus.Cancel) begin
            r_hi   <= w_fix_hi;
            r_lo   <= w_fix_lo;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy  = w_busy;
  assign bus.Stall = w_busy & (bus.Start | bus.ReadHiLo);
  assign bus.Done  = r_done;
  assign bus.Hi    = r_hi;
  assign bus.Lo    = r_lo;
  assign o_state   = r_state;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: arithmetic reference model checked every cycle, plus directed
// vectors with hand-computed HI/LO values.
module tb_muldiv_sequencer;
  localparam int W = 32;
  localparam logic [2:0] MULT = 3'b001, MULTU = 3'b010, DIV = 3'b011, DIVU = 3'b100;
  localparam logic [2:0] MTHI = 3'b101, MTLO = 3'b110;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         done_cnt = 0;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_sequencer #(.WIDTH(W)) dut (
    .Clk     (clk),
    .Rst     (rst_n),
    .bus     (bus),
    .o_state (dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (bus.Done === 1'b1) done_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result straight from the arithmetic definition: {hi, lo}.
  function automatic logic [63:0] model_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] res;
    sa = 64'(signed'(a));
    sb = 64'(signed'(b));
    res = '0;
    case (op)
      MULT:  res = sa * sb;
      MULTU: res = {32'b0, a} * {32'b0, b};
      DIV: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      DIVU: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  // Cycle model: an accepted MUL/DIV occupies the unit for WIDTH+1 edges, then writes HI/LO.
  logic        m_busy = 1'b0, m_done = 1'b0;
  int          m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0; m_hi <= '0; m_lo <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (bus.Cancel) m_busy <= 1'b0;
        else if (m_left == 1) begin
          m_busy <= 1'b0; m_done <= 1'b1; m_hi <= p_hi; m_lo <= p_lo;
        end else m_left <= m_left - 1;
      end else if (bus.Start && !bus.Cancel) begin
        case (bus.Op)
          MULT, MULTU, DIV, DIVU: begin
            {p_hi, p_lo} <= model_result(bus.Op, bus.A, bus.B);
            m_busy <= 1'b1;
            m_left <= W + 1;
          end
          MTHI: m_hi <= bus.A;
          MTLO: m_lo <= bus.A;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    check("busy", {31'b0, bus.Busy}, {31'b0, m_busy});
    check("done", {31'b0, bus.Done}, {31'b0, m_done});
    check("stall", {31'b0, bus.Stall}, {31'b0, m_busy & (bus.Start | bus.ReadHiLo)});
    check("hi", bus.Hi, m_hi);
    check("lo", bus.Lo, m_lo);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present an instruction and hold it until the unit takes it; returns the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int acc_cyc);
    int n;
    logic took;
    n = 0;
    took = 1'b0;
    bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b;
    while (!took && n < 200) begin
      took = !bus.Busy;
      @(posedge clk);
      #1;
      n++;
    end
    acc_cyc = cyc;
    bus.Start = 1'b0; bus.Op = 3'b000;
    check("issue_accepted", {31'b0, took}, 32'd1);
  endtask

  task automatic wait_idle(output int busy_cycles);
    busy_cycles = 0;
    while (bus.Busy && busy_cycles < 100) begin
      @(posedge clk);
      #1;
      busy_cycles++;
    end
    check("idle_within_bound", {31'b0, bus.Busy}, 32'd0);
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int e0, nb, d0;
    d0 = done_cnt;
    issue(op, a, b, e0);
    wait_idle(nb);
    check({name, "_busy_cycles"}, nb, 32'd33);
    check({name, "_done_now"}, {31'b0, bus.Done}, 32'd1);
    check({name, "_hi"}, bus.Hi, exp_hi);
    check({name, "_lo"}, bus.Lo, exp_lo);
    check({name, "_model_hi"}, m_hi, exp_hi);
    check({name, "_model_lo"}, m_lo, exp_lo);
    step(1);
    check({name, "_done_pulses"}, done_cnt - d0, 32'd1);
  endtask

  initial begin
    int e0, e1, d0;
    bus.Start = 1'b0; bus.Op = 3'b000; bus.A = '0; bus.B = '0;
    bus.ReadHiLo = 1'b0; bus.Cancel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hi", bus.Hi, 32'd0);
    check("rst_lo", bus.Lo, 32'd0);
    check("rst_busy", {31'b0, bus.Busy}, 32'd0);
    check("rst_done", {31'b0, bus.Done}, 32'd0);
    check("rst_stall", {31'b0, bus.Stall}, 32'd0);
    #1 rst_n = 1'b1;
    step(2);

    run_op("mult_m3x5", MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_m1xm1", MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1);
    run_op("mult_minxmin", MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    run_op("div_m7d2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_7d0", DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    run_op("div_m7d0", DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_op("divu_big", DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0000_000F, 32'h0FFF_FFFF);

    // ReadHiLo held from the fifth busy cycle, then a back-to-back MULTU behind the DIVU.
    issue(DIVU, 32'd100, 32'd7, e0);
    step(4);
    bus.ReadHiLo = 1'b1;
    issue(MULTU, 32'd3, 32'd4, e1);
    bus.ReadHiLo = 1'b0;
    check("b2b_accept_edge", e1 - e0, 32'd34);
    check("b2b_divu_hi", bus.Hi, 32'd2);
    check("b2b_divu_lo", bus.Lo, 32'd14);
    wait_idle(e0);
    check("b2b_multu_hi", bus.Hi, 32'd0);
    check("b2b_multu_lo", bus.Lo, 32'd12);
    step(2);

    issue(MTLO, 32'h0000_1234, 32'd0, e0);
    check("mtlo_lo", bus.Lo, 32'h0000_1234);
    check("mtlo_busy", {31'b0, bus.Busy}, 32'd0);
    step(1);

    issue(MULT, 32'd2, 32'd3, e0);
    issue(MTHI, 32'h0000_ABCD, 32'd0, e1);
    check("mthi_busy_accept_edge", e1 - e0, 32'd34);
    check("mthi_busy_hi", bus.Hi, 32'h0000_ABCD);
    check("mthi_busy_lo", bus.Lo, 32'd6);
    step(1);

    // Cancel at cycle 10 of a MULTU: no write, no Done.
    d0 = done_cnt;
    issue(MULTU, 32'd5, 32'd5, e0);
    step(9);
    bus.Cancel = 1'b1;
    step(1);
    bus.Cancel = 1'b0;
    check("cancel_busy", {31'b0, bus.Busy}, 32'd0);
    step(40);
    check("cancel_no_done", done_cnt - d0, 32'd0);
    check("cancel_hi", bus.Hi, 32'h0000_ABCD);
    check("cancel_lo", bus.Lo, 32'd6);

    // Cancel in idle swallows a same-cycle MTLO.
    bus.Start = 1'b1; bus.Op = MTLO; bus.A = 32'h5555_5555; bus.Cancel = 1'b1;
    step(1);
    bus.Start = 1'b0; bus.Op = 3'b000; bus.Cancel = 1'b0;
    check("cancel_idle_lo", bus.Lo, 32'd6);
    step(1);

    // Reset at cycle 20 of a DIV, asserted between clock edges.
    issue(DIV, 32'hFFFF_FF9C, 32'd7, e0);
    step(19);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_hi", bus.Hi, 32'd0);
    check("midrst_lo", bus.Lo, 32'd0);
    check("midrst_busy", {31'b0, bus.Busy}, 32'd0);
    check("midrst_done", {31'b0, bus.Done}, 32'd0);
    step(2);
    #1 rst_n = 1'b1;
    step(2);
    check("postrst_busy", {31'b0, bus.Busy}, 32'd0);

    run_op("div_m100d7", DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2);
    step(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle multiply/divide unit with its own sequencer and HI/LO registers, attached beside the ALU in the EX stage of the 5-stage pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, runs a fixed-latency iterative shift-add multiply or restoring divide, and holds the pipeline with `Stall` while a result is pending and EX needs the unit. HI/LO feed the EX-stage result path for MFHI/MFLO.

## Interface

- `WIDTH`, 32, operand and HI/LO width. Iteration count equals `WIDTH`.
- `Clk`  in  1  rising-edge clock.
- `Rst`  in  1  asynchronous reset, active-low.
- `Start`  in  1  EX holds a valid muldiv-class instruction this cycle.
- `Op`  in  3  operation code: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved.
- `A`  in  WIDTH  rs operand (dividend / multiplicand / MTHI/MTLO source).
- `B`  in  WIDTH  rt operand (divisor / multiplier).
- `ReadHiLo`  in  1  EX holds MFHI or MFLO this cycle.
- `Cancel`  in  1  abort the in-flight operation (branch/exception flush).
- `Stall`  out  1  combinational freeze request to PC, IF/ID and ID/EX.
- `Busy`  out  1  operation in flight.
- `Done`  out  1  one-cycle pulse: HI/LO just updated by MUL/DIV.
- `Hi`  out  WIDTH  HI register.
- `Lo`  out  WIDTH  LO register.

## Operation

- States: IDLE, MUL, DIV, FIX.
- IDLE, `Start` with Op 001/010: latch |A|, |B| (MULTU: raw operands) and result-sign flag. Clear the 6-bit iteration counter and the 2*WIDTH accumulator. Go to MUL.
- IDLE, `Start` with Op 011/100: latch operands and sign flags the same way. Go to DIV.
- IDLE, `Start` with Op 101/110: write A into Hi (101) or Lo (110) at that edge. Stay IDLE. No `Busy`, no `Done`.
- IDLE, `Start` with Op 000/111: ignored.
- MUL: one shift-add step per cycle, multiplier LSB first. After `WIDTH` steps, go to FIX.
- DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit). After `WIDTH` steps, go to FIX.
- FIX: conditionally negate, then write Hi/Lo and return to IDLE.
  - Product: negated if operand signs differ (signed only). Hi = upper half, Lo = lower half.
  - Division: quotient negated if signs differ. Remainder takes the dividend's sign. Lo = quotient, Hi = remainder.
  - FIX is always taken, so latency does not depend on operands.
- Divide by zero: no special path. Completes with normal latency and gives Lo = all ones, Hi = A (both DIVU and DIV; DIV with A negative yields Hi = A).
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: Lo = 0x80000000, Hi = 0.
- `Stall` = `Busy` & (`Start` | `ReadHiLo`). A `Start` arriving while busy is not accepted. The pipeline holds it and it is re-presented, then accepted on the edge after `Busy` falls.
- `Cancel` while Busy: return to IDLE at the next edge. Hi/Lo unchanged, no `Done`. `Cancel` in IDLE suppresses a same-cycle `Start` (including MTHI/MTLO).
- `Rst` low at any time, including mid-operation: state IDLE, Hi = Lo = 0, `Busy` = `Done` = 0, counter and accumulators cleared. No partial write.

## Timing

- Reset values: `Hi` 0, `Lo` 0, `Busy` 0, `Done` 0, `Stall` 0.
- `Start` sampled at edge E0 → `Busy` = 1 from E0.
- Iteration edges E1..E32. FIX edge E33 writes Hi/Lo and clears `Busy`.
- `Done` = 1 for exactly the cycle after E33. A new `Start` is accepted at E34 at the earliest.
- Latency: 33 cycles from accept to valid Hi/Lo, in general `WIDTH`+1.
- MTHI/MTLO: Hi/Lo valid the cycle after the accepting edge. Zero stall when idle.
- `Stall` is combinational from `Start`/`ReadHiLo`/`Busy`, with no registered delay. It is 0 during the `Done` cycle.
- Counter width is ceil(log2(`WIDTH`+1)). The accumulator is 2*`WIDTH` and never wraps.

## Test plan

- MULT A=0xFFFFFFFD (-3), B=5 → after 33 cycles Hi=0xFFFFFFFF, Lo=0xFFFFFFF1, `Done` pulses once, `Busy` high for exactly 33 cycles.
- MULTU A=B=0xFFFFFFFF → Hi=0xFFFFFFFE, Lo=0x00000001. Repeat as MULT → Hi=0, Lo=1.
- DIV A=-7, B=2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU A=7, B=0 → Lo=0xFFFFFFFF, Hi=7. DIV 0x80000000/-1 → Lo=0x80000000, Hi=0.
- Start DIVU, assert `ReadHiLo` on cycle 5 and hold → `Stall`=1 from cycle 5 through the FIX edge, 0 in the `Done` cycle. A back-to-back second `Start` is accepted at E34.
- MTLO A=0x1234 while idle → Lo=0x1234 next cycle, `Busy` stays 0. MTHI issued while busy → stalled, applied at E34.
- `Cancel` at cycle 10 of MULT → `Busy` 0 next cycle, Hi/Lo keep prior values, no `Done`. `Rst` low at cycle 20 of DIV → all outputs 0 immediately, with no clock edge needed.
